// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: PC register, small {instruction, pc} FIFO and branch redirect.
// Optional feature macro FETCH_HALT_EN: stop fetching once the CBZ XZR,#0 halt word is enqueued.
module fetch_unit #(
  parameter int            N        = 64,
  parameter int            AW       = 6,
  parameter int            DEPTH    = 2,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_q,
  input  logic          br_taken,
  input  logic [N-1:0]  br_target,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst,
  output logic [N-1:0]  inst_pc,
  output logic          halted
);

  localparam int             PW         = $clog2(DEPTH);
  localparam int             CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
  localparam logic [N-1:0]   PC_STEP    = N'(4);
  localparam logic [N-1:0]   ALIGN_MASK = ~(N'(3));

  logic [N-1:0]  pc_q, pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fifo_inst_q [DEPTH];
  logic [31:0]   fifo_inst_d [DEPTH];
  logic [N-1:0]  fifo_pc_q   [DEPTH];
  logic [N-1:0]  fifo_pc_d   [DEPTH];
  logic          halt_state;
  logic          pop_s;
  logic          push_s;

`ifdef FETCH_HALT_EN
  localparam logic [31:0] HALT_WORD = 32'hb400001f;
  logic halted_q, halted_d;
  assign halt_state = halted_q;
`else
  assign halt_state = 1'b0;
`endif

  assign imem_addr  = pc_q[AW+1:2];
  assign inst_valid = (count_q != {CW{1'b0}});
  assign pop_s      = inst_valid & inst_ready;
  assign push_s     = ~br_taken & ~halt_state & ((count_q < DEPTH_C) | pop_s);
  assign inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
  assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q] : {N{1'b0}};
  assign halted     = halt_state;

  // Redirect wins over everything: a same-cycle pop is still consumed, but the FIFO is cleared.
  always_comb begin
    pc_d        = pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    if (br_taken) begin
      pc_d     = br_target & ALIGN_MASK;
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        fifo_inst_d[wr_ptr_q] = imem_q;
        fifo_pc_d[wr_ptr_q]   = pc_q;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        pc_d                  = pc_q + PC_STEP;
      end else begin
        wr_ptr_d = wr_ptr_q;
        pc_d     = pc_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst_q[i] <= 32'h0;
        fifo_pc_q[i]   <= {N{1'b0}};
      end
    end else begin
      pc_q        <= pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

`ifdef FETCH_HALT_EN
  // The halt word itself is enqueued; only later pushes are blocked.
  always_comb begin
    halted_d = halted_q;
    if (br_taken) begin
      halted_d = 1'b0;
    end else if (push_s && (imem_q == HALT_WORD)) begin
      halted_d = 1'b1;
    end else begin
      halted_d = halted_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`endif

endmodule
